// File: rtl/xnor_popcount_accumulator.sv
// XNOR-popcount accumulator for one Filter_rows x Filter_Cols binarized window.
// Define XNOR_THRESHOLD_EN to add a signed threshold input for the activation compare.
module xnor_popcount_accumulator #(
  parameter int unsigned addressBitWidth = 16,
  parameter int unsigned accBitWidth     = 16,
  parameter int unsigned Filter_rows     = 2,
  parameter int unsigned Filter_Cols     = 5
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          startSingleConv,
  input  logic                          beat_valid,
  input  logic [addressBitWidth-1:0]    hm_address_img,
  input  logic [addressBitWidth-1:0]    vm_address_img,
  input  logic                          img_bit,
  input  logic                          wgt_bit,
  input  logic                          DPDone,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic signed [accBitWidth-1:0] dp_sum,
  output logic                          act_bit,
  output logic                          busy,
  output logic                          addr_err,
  output logic                          count_err
`ifdef XNOR_THRESHOLD_EN
  ,
  input  logic signed [accBitWidth-1:0] threshold
`endif
);

  localparam int unsigned N    = Filter_rows * Filter_Cols;
  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StAccum, StResult} state_e;

  state_e                       state_q, state_d;
  logic [CntW-1:0]              match_cnt_q, match_cnt_d;
  logic [CntW-1:0]              beat_cnt_q, beat_cnt_d;
  logic [addressBitWidth-1:0]   exp_hm_q, exp_hm_d;
  logic [addressBitWidth-1:0]   exp_vm_q, exp_vm_d;
  logic                         addr_err_q, addr_err_d;
  logic                         count_err_q, count_err_d;
  logic signed [accBitWidth-1:0] dp_sum_q, dp_sum_d;
  logic                         act_bit_q, act_bit_d;
  logic                         restart;
  logic signed [accBitWidth-1:0] sum_c;

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    exp_hm_d    = exp_hm_q;
    exp_vm_d    = exp_vm_q;
    addr_err_d  = addr_err_q;
    count_err_d = count_err_q;
    dp_sum_d    = dp_sum_q;
    act_bit_d   = act_bit_q;
    restart     = 1'b0;
    sum_c       = '0;

    unique case (state_q)
      StIdle: begin
        if (startSingleConv) begin
          state_d = StAccum;
          restart = 1'b1;
        end
      end

      StAccum: begin
        if (startSingleConv && !DPDone) begin
          restart = 1'b1;
        end else begin
          if (beat_valid) begin
            if (beat_cnt_q < CntW'(N)) begin
              beat_cnt_d = beat_cnt_q + CntW'(1);
              if (img_bit == wgt_bit) begin
                match_cnt_d = match_cnt_q + CntW'(1);
              end
              if ((hm_address_img != exp_hm_q) || (vm_address_img != exp_vm_q)) begin
                addr_err_d = 1'b1;
              end
              // Raster order: vm is the inner index.
              if (exp_vm_q == addressBitWidth'(Filter_Cols - 1)) begin
                exp_vm_d = '0;
                exp_hm_d = exp_hm_q + addressBitWidth'(1);
              end else begin
                exp_vm_d = exp_vm_q + addressBitWidth'(1);
              end
            end else begin
              count_err_d = 1'b1;
            end
          end
          if (DPDone) begin
            // Uses the counts including any beat arriving alongside DPDone.
            sum_c    = $signed((accBitWidth'(match_cnt_d) << 1) - accBitWidth'(beat_cnt_d));
            dp_sum_d = sum_c;
`ifdef XNOR_THRESHOLD_EN
            act_bit_d = (sum_c >= threshold);
`else
            act_bit_d = ~sum_c[accBitWidth-1];
`endif
            if (beat_cnt_d != CntW'(N)) begin
              count_err_d = 1'b1;
            end
            state_d = StResult;
          end
        end
      end

      StResult: begin
        if (res_ready) begin
          if (startSingleConv) begin
            state_d = StAccum;
            restart = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    if (restart) begin
      match_cnt_d = '0;
      beat_cnt_d  = '0;
      exp_hm_d    = '0;
      exp_vm_d    = '0;
      addr_err_d  = 1'b0;
      count_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      match_cnt_q <= '0;
      beat_cnt_q  <= '0;
      exp_hm_q    <= '0;
      exp_vm_q    <= '0;
      addr_err_q  <= 1'b0;
      count_err_q <= 1'b0;
      dp_sum_q    <= '0;
      act_bit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      exp_hm_q    <= exp_hm_d;
      exp_vm_q    <= exp_vm_d;
      addr_err_q  <= addr_err_d;
      count_err_q <= count_err_d;
      dp_sum_q    <= dp_sum_d;
      act_bit_q   <= act_bit_d;
    end
  end

  assign res_valid = (state_q == StResult);
  assign busy      = (state_q == StAccum);
  assign dp_sum    = dp_sum_q;
  assign act_bit   = act_bit_q;
  assign addr_err  = addr_err_q;
  assign count_err = count_err_q;

  a_hold_stable: assert property (@(posedge clk) disable iff (!reset_n)
    res_valid && !res_ready |=> res_valid && $stable(dp_sum) && $stable(act_bit));

  a_busy_excl: assert property (@(posedge clk) disable iff (!reset_n) !(busy && res_valid));

endmodule

// File: tb/tb_xnor_popcount_accumulator.sv
// Scoreboard bench for xnor_popcount_accumulator: expected results queued at DPDone,
// compared when res_valid appears.
module tb_xnor_popcount_accumulator;

  localparam int Rows = 2;
  localparam int Cols = 5;
  localparam int N    = Rows * Cols;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        startSingleConv = 1'b0;
  logic        beat_valid = 1'b0;
  logic [15:0] hm_address_img = '0;
  logic [15:0] vm_address_img = '0;
  logic        img_bit = 1'b0;
  logic        wgt_bit = 1'b0;
  logic        DPDone = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] dp_sum;
  logic        act_bit;
  logic        busy;
  logic        addr_err;
  logic        count_err;
`ifdef XNOR_THRESHOLD_EN
  logic signed [15:0] threshold = 16'sd4;
`endif

  xnor_popcount_accumulator #(
    .addressBitWidth(16),
    .accBitWidth    (16),
    .Filter_rows    (Rows),
    .Filter_Cols    (Cols)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .startSingleConv(startSingleConv),
    .beat_valid     (beat_valid),
    .hm_address_img (hm_address_img),
    .vm_address_img (vm_address_img),
    .img_bit        (img_bit),
    .wgt_bit        (wgt_bit),
    .DPDone         (DPDone),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .dp_sum         (dp_sum),
    .act_bit        (act_bit),
    .busy           (busy),
    .addr_err       (addr_err),
    .count_err      (count_err)
`ifdef XNOR_THRESHOLD_EN
    ,
    .threshold      (threshold)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    bit act;
    bit aerr;
    bit cerr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(want));
    end
  endtask

  function automatic bit exp_act(input int s);
`ifdef XNOR_THRESHOLD_EN
    return s >= int'(threshold);
`else
    return s >= 0;
`endif
  endfunction

  task automatic start_win();
    startSingleConv = 1'b1;
    @(negedge clk);
    startSingleConv = 1'b0;
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_aerr", 32'(addr_err), 32'd0);
    check_eq("start_cerr", 32'(count_err), 32'd0);
  endtask

  // Beat i carries raster address (i/Cols, i%Cols) unless i == bad.
  task automatic send_beats(input int n, input logic [15:0] mism, input int bad, input bit merge,
                            output int m, output int b);
    m = 0;
    b = 0;
    for (int i = 0; i < n; i++) begin
      beat_valid     = 1'b1;
      hm_address_img = (i == bad) ? 16'd1 : 16'(i / Cols);
      vm_address_img = (i == bad) ? 16'd0 : 16'(i % Cols);
      img_bit        = 1'($urandom_range(0, 1));
      wgt_bit        = mism[i] ? ~img_bit : img_bit;
      if (i < N) begin
        b++;
        if (!mism[i]) m++;
      end
      if (merge && i == n - 1) DPDone = 1'b1;
      @(negedge clk);
    end
    beat_valid = 1'b0;
    DPDone     = 1'b0;
  endtask

  task automatic collect(input int hold, input bit start_next);
    exp_t e;
    int   waited = 0;
    while (!res_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("res_valid", 32'(res_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    if (!res_valid) return;
    check_eq("dp_sum", 32'($signed(dp_sum)), 32'(e.sum));
    check_eq("act_bit", 32'(act_bit), 32'(e.act));
    check_eq("addr_err", 32'(addr_err), 32'(e.aerr));
    check_eq("count_err", 32'(count_err), 32'(e.cerr));
    for (int i = 0; i < hold; i++) begin
      // A start without ready must be ignored.
      startSingleConv = (i == 0);
      @(negedge clk);
      startSingleConv = 1'b0;
      check_eq("hold_valid", 32'(res_valid), 32'd1);
      check_eq("hold_sum", 32'($signed(dp_sum)), 32'(e.sum));
    end
    res_ready       = 1'b1;
    startSingleConv = start_next;
    @(negedge clk);
    res_ready       = 1'b0;
    startSingleConv = 1'b0;
    check_eq("res_drop", 32'(res_valid), 32'd0);
    check_eq("post_busy", 32'(busy), 32'(start_next));
  endtask

  task automatic window(input int n, input logic [15:0] mism, input int bad, input int hold,
                        input bit do_start, input bit merge, input bit start_next);
    exp_t e;
    int   m;
    int   b;
    if (do_start) start_win();
    send_beats(n, mism, bad, merge, m, b);
    if (n > N) check_eq("drop_err", 32'(count_err), 32'd1);
    e.sum  = 2 * m - b;
    e.act  = exp_act(e.sum);
    e.aerr = (bad >= 0) && (bad < n) && (bad < N);
    e.cerr = (n != N);
    exp_q.push_back(e);
    if (!merge) begin
      DPDone = 1'b1;
      @(negedge clk);
      DPDone = 1'b0;
    end
    collect(hold, start_next);
  endtask

  initial begin
    int m;
    int b;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_valid", 32'(res_valid), 32'd0);
    check_eq("rst_sum", 32'(dp_sum), 32'd0);
    check_eq("rst_act", 32'(act_bit), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_errs", 32'({addr_err, count_err}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    window(10, 16'h0000, -1, 0, 1, 0, 0);  // all matches: +10
    window(10, 16'h03FF, -1, 0, 1, 0, 0);  // all mismatches: -10
    window(10, 16'h000F, -1, 3, 1, 0, 0);  // 6 of 10, held 3 cycles: +2
    window(10, 16'h0007, -1, 0, 1, 0, 0);  // 7 of 10: +4
    window(10, 16'h0000, 3, 0, 1, 0, 0);   // address fault on 4th beat
    window(7, 16'h0000, -1, 0, 1, 0, 0);   // early DPDone: +7, count_err
    window(11, 16'h0000, -1, 0, 1, 0, 0);  // 11th beat dropped
    window(10, 16'h0255, -1, 1, 1, 1, 0);  // last beat alongside DPDone
    window(10, 16'h0100, -1, 0, 1, 0, 1);  // start in transfer cycle
    window(10, 16'h0300, -1, 0, 0, 0, 0);  // runs on that start

    // Restart mid-window discards the partial sum.
    start_win();
    send_beats(4, 16'h000F, -1, 0, m, b);
    window(10, 16'h0000, -1, 0, 1, 0, 0);

    // beat_valid and DPDone in IDLE produce nothing.
    beat_valid = 1'b1;
    DPDone     = 1'b1;
    @(negedge clk);
    beat_valid = 1'b0;
    DPDone     = 1'b0;
    @(negedge clk);
    check_eq("idle_valid", 32'(res_valid), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Reset mid-ACCUM clears everything immediately.
    start_win();
    send_beats(3, 16'h0000, 1, 0, m, b);
    reset_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_valid", 32'(res_valid), 32'd0);
    check_eq("arst_sum", 32'(dp_sum), 32'd0);
    check_eq("arst_act", 32'(act_bit), 32'd0);
    check_eq("arst_errs", 32'({addr_err, count_err}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    window(10, 16'h0021, -1, 0, 1, 0, 0);  // recovers after reset: +6

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
